// File: rtl/mips_operand_fetch.sv
// MIPS operand-fetch stage. It issues the register-file reads, absorbs the 1-cycle RF read latency,
// and hands decoded fields plus operands to execute. Define MIPS_OF_BYPASS_EN to forward snooped RF writes.
module mips_operand_fetch #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_instr,
    output logic                 rf_r_1_en,
    output logic [RF_ADDR_W-1:0] rf_addr_r_1,
    input  logic [DATA_W-1:0]    rf_r_data_1,
    output logic                 rf_r_2_en,
    output logic [RF_ADDR_W-1:0] rf_addr_r_2,
    input  logic [DATA_W-1:0]    rf_r_data_2,
    input  logic                 wb_en,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_rs_val,
    output logic [DATA_W-1:0]    out_rt_val,
    output logic [DATA_W-1:0]    out_imm,
    output logic [5:0]           out_opcode,
    output logic [5:0]           out_funct,
    output logic [4:0]           out_shamt,
    output logic [4:0]           out_rt_idx,
    output logic [4:0]           out_rd_idx
);

    localparam int PAD_W = RF_ADDR_W - 5;

    // Stage A: instruction whose RF data arrives this cycle, plus per-operand hold registers
    logic              r_a_valid;
    logic [DATA_W-1:0] r_a_instr;
    logic              r_a_rs_use_hold;
    logic              r_a_rt_use_hold;
    logic [DATA_W-1:0] r_a_rs_hold;
    logic [DATA_W-1:0] r_a_rt_hold;

    // Stage B: output register
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_rs_val;
    logic [DATA_W-1:0] r_out_rt_val;
    logic [DATA_W-1:0] r_out_imm;
    logic [5:0]        r_out_opcode;
    logic [5:0]        r_out_funct;
    logic [4:0]        r_out_shamt;
    logic [4:0]        r_out_rt_idx;
    logic [4:0]        r_out_rd_idx;
    logic [4:0]        r_b_rs_idx;

    logic              w_accept;
    logic              w_b_load;
    logic [4:0]        w_in_rs_idx;
    logic [4:0]        w_in_rt_idx;
    logic [4:0]        w_a_rs_idx;
    logic [4:0]        w_a_rt_idx;
    logic [DATA_W-1:0] w_a_rs_base;
    logic [DATA_W-1:0] w_a_rt_base;
    logic [DATA_W-1:0] w_a_rs;
    logic [DATA_W-1:0] w_a_rt;
    logic              w_hit_in_rs;
    logic              w_hit_in_rt;
    logic              w_hit_a_rs;
    logic              w_hit_a_rt;
    logic              w_hit_b_rs;
    logic              w_hit_b_rt;

    assign w_b_load    = r_a_valid & (~r_out_valid | out_ready);
    assign in_ready    = ~r_a_valid | w_b_load;
    assign w_accept    = in_valid & in_ready & ~arst;

    assign w_in_rs_idx = in_instr[25:21];
    assign w_in_rt_idx = in_instr[20:16];
    assign w_a_rs_idx  = r_a_instr[25:21];
    assign w_a_rt_idx  = r_a_instr[20:16];

    assign rf_r_1_en   = w_accept;
    assign rf_r_2_en   = w_accept;
    assign rf_addr_r_1 = {{PAD_W{1'b0}}, w_in_rs_idx};
    assign rf_addr_r_2 = {{PAD_W{1'b0}}, w_in_rt_idx};

`ifdef MIPS_OF_BYPASS_EN
    function automatic logic wb_match(input logic en, input logic [RF_ADDR_W-1:0] addr,
                                      input logic [4:0] idx);
        return en && (idx != 5'd0) && (addr == {{PAD_W{1'b0}}, idx});
    endfunction

    assign w_hit_in_rs = wb_match(wb_en, wb_addr, w_in_rs_idx);
    assign w_hit_in_rt = wb_match(wb_en, wb_addr, w_in_rt_idx);
    assign w_hit_a_rs  = wb_match(wb_en, wb_addr, w_a_rs_idx);
    assign w_hit_a_rt  = wb_match(wb_en, wb_addr, w_a_rt_idx);
    assign w_hit_b_rs  = wb_match(wb_en, wb_addr, r_b_rs_idx);
    assign w_hit_b_rt  = wb_match(wb_en, wb_addr, r_out_rt_idx);
`else
    assign w_hit_in_rs = 1'b0;
    assign w_hit_in_rt = 1'b0;
    assign w_hit_a_rs  = 1'b0;
    assign w_hit_a_rt  = 1'b0;
    assign w_hit_b_rs  = 1'b0;
    assign w_hit_b_rt  = 1'b0;
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en, wb_addr};
`endif

    // Operand priority: $0 forces zero, then a write this cycle, then the held/captured value, then RF data
    assign w_a_rs_base = r_a_rs_use_hold ? r_a_rs_hold : rf_r_data_1;
    assign w_a_rt_base = r_a_rt_use_hold ? r_a_rt_hold : rf_r_data_2;
    assign w_a_rs      = (w_a_rs_idx == 5'd0) ? '0 : (w_hit_a_rs ? wb_data : w_a_rs_base);
    assign w_a_rt      = (w_a_rt_idx == 5'd0) ? '0 : (w_hit_a_rt ? wb_data : w_a_rt_base);

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_a_valid       <= 1'b0;
            r_a_instr       <= '0;
            r_a_rs_use_hold <= 1'b0;
            r_a_rt_use_hold <= 1'b0;
            r_a_rs_hold     <= '0;
            r_a_rt_hold     <= '0;
        end else if (w_accept) begin
            r_a_valid       <= 1'b1;
            r_a_instr       <= in_instr;
            r_a_rs_use_hold <= w_hit_in_rs;
            r_a_rt_use_hold <= w_hit_in_rt;
            r_a_rs_hold     <= wb_data;
            r_a_rt_hold     <= wb_data;
        end else if (w_b_load) begin
            r_a_valid       <= 1'b0;
        end else if (r_a_valid) begin
            // RF data is only valid for one cycle, so a blocked A keeps its operands locally
            r_a_rs_use_hold <= 1'b1;
            r_a_rt_use_hold <= 1'b1;
            r_a_rs_hold     <= w_a_rs;
            r_a_rt_hold     <= w_a_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_out_valid  <= 1'b0;
            r_out_rs_val <= '0;
            r_out_rt_val <= '0;
            r_out_imm    <= '0;
            r_out_opcode <= '0;
            r_out_funct  <= '0;
            r_out_shamt  <= '0;
            r_out_rt_idx <= '0;
            r_out_rd_idx <= '0;
            r_b_rs_idx   <= '0;
        end else if (w_b_load) begin
            r_out_valid  <= 1'b1;
            r_out_rs_val <= w_a_rs;
            r_out_rt_val <= w_a_rt;
            r_out_imm    <= {{(DATA_W-16){r_a_instr[15]}}, r_a_instr[15:0]};
            r_out_opcode <= r_a_instr[31:26];
            r_out_funct  <= r_a_instr[5:0];
            r_out_shamt  <= r_a_instr[10:6];
            r_out_rt_idx <= w_a_rt_idx;
            r_out_rd_idx <= r_a_instr[15:11];
            r_b_rs_idx   <= w_a_rs_idx;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && !out_ready) begin
                if (w_hit_b_rs) r_out_rs_val <= wb_data;
                if (w_hit_b_rt) r_out_rt_val <= wb_data;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_rs_val = r_out_rs_val;
    assign out_rt_val = r_out_rt_val;
    assign out_imm    = r_out_imm;
    assign out_opcode = r_out_opcode;
    assign out_funct  = r_out_funct;
    assign out_shamt  = r_out_shamt;
    assign out_rt_idx = r_out_rt_idx;
    assign out_rd_idx = r_out_rd_idx;

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Self-checking bench for mips_operand_fetch: directed vector table, stall/reset sequences and a
// randomized run scored against an architectural register-file model (honours MIPS_OF_BYPASS_EN).
module tb_mips_operand_fetch;

`ifdef MIPS_OF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        rf_r_1_en;
    logic [5:0]  rf_addr_r_1;
    logic [31:0] rf_r_data_1 = '0;
    logic        rf_r_2_en;
    logic [5:0]  rf_addr_r_2;
    logic [31:0] rf_r_data_2 = '0;
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [31:0] out_imm;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [4:0]  out_shamt;
    logic [4:0]  out_rt_idx;
    logic [4:0]  out_rd_idx;

    mips_operand_fetch #(.DATA_W(32), .RF_ADDR_W(6)) dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_r_1_en(rf_r_1_en), .rf_addr_r_1(rf_addr_r_1), .rf_r_data_1(rf_r_data_1),
        .rf_r_2_en(rf_r_2_en), .rf_addr_r_2(rf_addr_r_2), .rf_r_data_2(rf_r_data_2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
        .out_rt_idx(out_rt_idx), .out_rd_idx(out_rd_idx)
    );

    always #5 clk = ~clk;

    // Register file with a registered read that returns the pre-write value on a same-edge write
    logic [31:0] rf [32] = '{default: 32'd0};
    always @(posedge clk) begin
        if (rf_r_1_en) rf_r_data_1 <= rf[rf_addr_r_1[4:0]];
        if (rf_r_2_en) rf_r_data_2 <= rf[rf_addr_r_2[4:0]];
        if (wb_en) rf[wb_addr[4:0]] <= wb_data;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard entry: the instruction and its register values as seen in the accept cycle
    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_cap;
        logic [31:0] rt_cap;
    } ent_t;
    ent_t q[$];

    // With forwarding the operand equals the architectural value now; without it, the value at accept
    function automatic logic [31:0] exp_op(input logic [4:0] idx, input logic [31:0] cap);
        if (idx == 5'd0) return 32'd0;
        return BYP ? rf[idx] : cap;
    endfunction

    task automatic observe();
        ent_t h;
        logic [31:0] f;
        if (arst) begin
            q.delete();
            return;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
            end else begin
                h = q[0];
                f = {6'd0, h.instr[31:26], h.instr[5:0], h.instr[10:6], h.instr[20:16], h.instr[15:11]};
                check("sb_rs_val", out_rs_val, exp_op(h.instr[25:21], h.rs_cap));
                check("sb_rt_val", out_rt_val, exp_op(h.instr[20:16], h.rt_cap));
                check("sb_imm", out_imm, 32'($signed(h.instr[15:0])));
                check("sb_fields", {6'd0, out_opcode, out_funct, out_shamt, out_rt_idx, out_rd_idx}, f);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_delivered++;
                end
            end
        end
        if (in_valid && in_ready) begin
            h.instr  = in_instr;
            h.rs_cap = rf[in_instr[25:21]];
            h.rt_cap = rf[in_instr[20:16]];
            q.push_back(h);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        observe();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] idx, input logic [31:0] val);
        wb_en = 1'b1;
        wb_addr = {1'b0, idx};
        wb_data = val;
        to_neg();
        to_pos();
        wb_en = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs_init;
        logic [31:0] rt_init;
        logic [1:0]  wb_when;   // 0 none, 1 accept cycle, 2 the following cycle
        logic [4:0]  wb_reg;
        logic [31:0] wb_val;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_imm;
    } vec_t;

    task automatic apply_vec(input int k, input vec_t v);
        rf_write(v.instr[25:21], v.rs_init);
        rf_write(v.instr[20:16], v.rt_init);
        in_valid = 1'b1; in_instr = v.instr; out_ready = 1'b1;
        wb_en = (v.wb_when == 2'd1); wb_addr = {1'b0, v.wb_reg}; wb_data = v.wb_val;
        to_neg();
        check($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
        check($sformatf("v%0d_rf_en", k), {30'd0, rf_r_1_en, rf_r_2_en}, 32'd3);
        check($sformatf("v%0d_rf_addr", k), {20'd0, rf_addr_r_1, rf_addr_r_2},
              {20'd0, 1'b0, v.instr[25:21], 1'b0, v.instr[20:16]});
        to_pos();
        in_valid = 1'b0;
        wb_en = (v.wb_when == 2'd2);
        to_neg();
        check($sformatf("v%0d_valid_t1", k), {31'd0, out_valid}, 32'd0);
        to_pos();
        wb_en = 1'b0;
        to_neg();
        check($sformatf("v%0d_valid_t2", k), {31'd0, out_valid}, 32'd1);
        check($sformatf("v%0d_rs", k), out_rs_val, v.exp_rs);
        check($sformatf("v%0d_rt", k), out_rt_val, v.exp_rt);
        check($sformatf("v%0d_imm", k), out_imm, v.exp_imm);
        check($sformatf("v%0d_rd_funct", k), {21'd0, out_rd_idx, out_funct},
              {21'd0, v.instr[15:11], v.instr[5:0]});
        to_pos();
        to_neg();
        check($sformatf("v%0d_valid_after", k), {31'd0, out_valid}, 32'd0);
        to_pos();
    endtask

    initial begin
        vec_t vecs[6];
        int   base;

        vecs[0] = '{instr: 32'h00221820, rs_init: 32'd5, rt_init: 32'd7, wb_when: 2'd0, wb_reg: 5'd0,
                    wb_val: 32'd0, exp_rs: 32'd5, exp_rt: 32'd7, exp_imm: 32'h00001820};
        vecs[1] = '{instr: 32'h00221820, rs_init: 32'd5, rt_init: 32'd7, wb_when: 2'd1, wb_reg: 5'd1,
                    wb_val: 32'h11, exp_rs: BYP ? 32'h11 : 32'd5, exp_rt: 32'd7, exp_imm: 32'h00001820};
        vecs[2] = '{instr: 32'h00221820, rs_init: 32'd5, rt_init: 32'd7, wb_when: 2'd2, wb_reg: 5'd1,
                    wb_val: 32'h11, exp_rs: BYP ? 32'h11 : 32'd5, exp_rt: 32'd7, exp_imm: 32'h00001820};
        vecs[3] = '{instr: 32'h2004FFFF, rs_init: 32'h1234, rt_init: 32'h44, wb_when: 2'd1, wb_reg: 5'd0,
                    wb_val: 32'hFFFF, exp_rs: 32'd0, exp_rt: 32'h44, exp_imm: 32'hFFFFFFFF};
        vecs[4] = '{instr: 32'h00A52820, rs_init: 32'h100, rt_init: 32'h100, wb_when: 2'd2, wb_reg: 5'd5,
                    wb_val: 32'hABC, exp_rs: BYP ? 32'hABC : 32'h100, exp_rt: BYP ? 32'hABC : 32'h100,
                    exp_imm: 32'h00002820};
        vecs[5] = '{instr: 32'h8D28FFFC, rs_init: 32'h1000, rt_init: 32'h2222, wb_when: 2'd1, wb_reg: 5'd6,
                    wb_val: 32'h99, exp_rs: 32'h1000, exp_rt: 32'h2222, exp_imm: 32'hFFFFFFFC};

        arst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        to_pos();
        to_neg();
        to_pos();
        arst = 1'b0;
        to_neg();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_data", out_rs_val | out_rt_val | out_imm, 32'd0);
        to_pos();

        for (int k = 0; k < 6; k++) apply_vec(k, vecs[k]);

        // Stall: three back-to-back instructions against a blocked consumer
        rf_write(5'd1, 32'd5);
        rf_write(5'd2, 32'd7);
        rf_write(5'd5, 32'h100);
        base = n_delivered;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00221820;
        to_neg(); check("stall_accept0", {31'd0, in_ready}, 32'd1); to_pos();
        in_instr = 32'h00411822;
        to_neg(); check("stall_accept1", {31'd0, in_ready}, 32'd1); to_pos();
        in_instr = 32'h00A52820;
        wb_en = 1'b1; wb_addr = 6'd2; wb_data = 32'h77;
        to_neg(); check("stall_full_c2", {31'd0, in_ready}, 32'd0); to_pos();
        wb_en = 1'b0;
        to_neg(); check("stall_full_c3", {31'd0, in_ready}, 32'd0); to_pos();
        out_ready = 1'b1;
        to_neg(); check("stall_release", {31'd0, in_ready}, 32'd1); to_pos();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            to_neg();
            to_pos();
        end
        check("stall_delivered", 32'(n_delivered - base), 32'd3);
        check("stall_drained", 32'(q.size()), 32'd0);

        // Reset with both stages occupied, then a fresh instruction
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820;
        to_neg(); to_pos();
        in_instr = 32'h00411822;
        to_neg(); to_pos();
        arst = 1'b1; in_instr = 32'h00A52820;
        to_neg();
        check("rst_rf_en", {30'd0, rf_r_1_en, rf_r_2_en}, 32'd0);
        to_pos();
        arst = 1'b0; in_valid = 1'b0;
        to_neg();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_rs_val | out_imm, 32'd0);
        to_pos();
        out_ready = 1'b1; in_valid = 1'b1;
        to_neg(); to_pos();
        in_valid = 1'b0;
        to_neg(); check("rst_lat_t1", {31'd0, out_valid}, 32'd0); to_pos();
        to_neg(); check("rst_lat_t2", {31'd0, out_valid}, 32'd1); to_pos();
        to_neg(); to_pos();
        check("rst_drained", 32'(q.size()), 32'd0);

        // Randomized traffic over a small register window to provoke hazards
        for (int r = 0; r < 8; r++) rf_write(5'(r), $urandom());
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w;
            w = $urandom();
            w[25:21] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            in_instr  = w;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_addr   = 6'($urandom_range(0, 7));
            wb_data   = $urandom();
            to_neg();
            to_pos();
        end
        in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            to_neg();
            to_pos();
        end
        check("rand_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
